// File: rtl/norm1_pkg.sv
// Shared helpers for the norm1 multiplier datapath: product width, signed
// saturation bounds and the round-half-up constant.
package norm1_pkg;

  // Wide enough for the saturation comparison of any realistic norm1 width.
  localparam int MAX_W = 256;

  function automatic int prod_w(input int w0, input int w1);
    return w0 + w1 + 1;
  endfunction

  function automatic logic signed [MAX_W-1:0] sat_max(input int w);
    logic [MAX_W-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return $signed((one << (w - 1)) - one);
  endfunction

  function automatic logic signed [MAX_W-1:0] sat_min(input int w);
    logic [MAX_W-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return -$signed(one << (w - 1));
  endfunction

  function automatic logic [MAX_W-1:0] round_const(input int shift);
    logic [MAX_W-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    if (shift <= 0) return '0;
    return one << (shift - 1);
  endfunction

endpackage

// File: rtl/norm1_pipe_stage.sv
// One valid/ready register slice; holds data and valid while the next slice
// is stalled, so nothing is dropped or duplicated.
module norm1_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign ready_o = ~valid_q | ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  // Data is reset too so the result port reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/norm1_mul_pipe.sv
// Pipelined signed x (un)signed multiplier with round-half-up shift and
// output saturation; NUM_STAGE valid/ready slices with no skid buffer.
module norm1_mul_pipe
  import norm1_pkg::*;
#(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 3,
  parameter int din0_WIDTH  = 9,
  parameter int din1_WIDTH  = 45,
  parameter int DIN1_SIGNED = 0,
  parameter int dout_WIDTH  = 52,
  parameter int SHIFT       = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int OPW  = din0_WIDTH + din1_WIDTH;
  localparam int PW   = prod_w(din0_WIDTH, din1_WIDTH);
  localparam int RW   = PW + 1;
  localparam int OUTW = dout_WIDTH + 1;

  localparam logic signed [MAX_W-1:0] SMAX = sat_max(dout_WIDTH);
  localparam logic signed [MAX_W-1:0] SMIN = sat_min(dout_WIDTH);
  localparam logic        [MAX_W-1:0] RC   = round_const(SHIFT);

  function automatic logic signed [PW-1:0] mul_fn(input logic [din0_WIDTH-1:0] a,
                                                  input logic [din1_WIDTH-1:0] b);
    logic signed [PW-1:0] ax, bx;
    ax = {{(PW - din0_WIDTH){a[din0_WIDTH-1]}}, a};
    bx = {{(PW - din1_WIDTH){(DIN1_SIGNED != 0) && b[din1_WIDTH-1]}}, b};
    return ax * bx;
  endfunction

  function automatic logic signed [RW-1:0] round_fn(input logic signed [PW-1:0] p);
    logic signed [RW-1:0] px;
    px = {p[PW-1], p};
    if (SHIFT > 0) px = (px + $signed(RC[RW-1:0])) >>> SHIFT;
    return px;
  endfunction

  // Packed as {ovf, dout}.
  function automatic logic [OUTW-1:0] sat_fn(input logic signed [RW-1:0] r);
    logic signed [MAX_W-1:0] rx;
    rx = {{(MAX_W - RW){r[RW-1]}}, r};
    if (rx > SMAX) return {1'b1, SMAX[dout_WIDTH-1:0]};
    if (rx < SMIN) return {1'b1, SMIN[dout_WIDTH-1:0]};
    return {1'b0, rx[dout_WIDTH-1:0]};
  endfunction

  // Slice 0 holds operands, slice 1 the raw product, slice 2 onward the
  // saturated result; shallower pipes fold the arithmetic forward.
  function automatic int stage_w(input int k);
    if (NUM_STAGE == 1) return OUTW;
    if (k == 0) return OPW;
    if (k == 1 && NUM_STAGE > 2) return PW;
    return OUTW;
  endfunction

  logic [NUM_STAGE:0] vld;
  logic [NUM_STAGE:0] rdy;

  assign vld[0]         = in_valid;
  assign rdy[NUM_STAGE] = out_ready;

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stg
    localparam int SW = stage_w(k);
    logic [SW-1:0] d_in;
    logic [SW-1:0] d_out;

    if (k == 0) begin : g_in
      if (NUM_STAGE == 1) begin : g_all
        assign d_in = sat_fn(round_fn(mul_fn(din0, din1)));
      end else begin : g_ops
        assign d_in = {din0, din1};
      end
    end else if (k == 1 && NUM_STAGE == 2) begin : g_mrs
      assign d_in = sat_fn(round_fn(mul_fn(g_stg[0].d_out[OPW-1:din1_WIDTH],
                                           g_stg[0].d_out[din1_WIDTH-1:0])));
    end else if (k == 1) begin : g_mul
      assign d_in = mul_fn(g_stg[0].d_out[OPW-1:din1_WIDTH],
                           g_stg[0].d_out[din1_WIDTH-1:0]);
    end else if (k == 2) begin : g_rs
      assign d_in = sat_fn(round_fn(g_stg[1].d_out));
    end else begin : g_pass
      assign d_in = g_stg[k-1].d_out;
    end

    norm1_pipe_stage #(
      .W(SW)
    ) u_stage (
      .clk_i  (ap_clk),
      .rst_ni (ap_rst_n),
      .valid_i(vld[k]),
      .ready_o(rdy[k]),
      .data_i (d_in),
      .valid_o(vld[k+1]),
      .ready_i(rdy[k+1]),
      .data_o (d_out)
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[NUM_STAGE];
  assign dout      = g_stg[NUM_STAGE-1].d_out[dout_WIDTH-1:0];
  assign ovf       = g_stg[NUM_STAGE-1].d_out[dout_WIDTH];

endmodule

// File: tb/tb_norm1_mul_pipe.sv
// Directed bench for norm1_mul_pipe: three instances (defaults, SHIFT=4,
// signed din1) sharing one clock and reset.
module tb_norm1_mul_pipe;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        iv    [3];
  logic        irdy  [3];
  logic [8:0]  d0    [3];
  logic [44:0] d1    [3];
  logic        ov    [3];
  logic        ordy  [3];
  logic [51:0] dq    [3];
  logic        ovfv  [3];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 ap_clk = ~ap_clk;

  norm1_mul_pipe dut0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .din0(d0[0]), .din1(d1[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .dout(dq[0]), .ovf(ovfv[0]));

  norm1_mul_pipe #(.SHIFT(4)) dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .din0(d0[1]), .din1(d1[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .dout(dq[1]), .ovf(ovfv[1]));

  norm1_mul_pipe #(.DIN1_SIGNED(1)) dut2 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .din0(d0[2]), .din1(d1[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .dout(dq[2]), .ovf(ovfv[2]));

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Independent model for the default configuration (SHIFT=0, unsigned din1).
  function automatic longint ref_p(input logic signed [8:0] a, input logic [44:0] b);
    longint pa, pb;
    pa = longint'(a);
    pb = longint'({19'b0, b});
    return pa * pb;
  endfunction

  function automatic longint ref_dout(input logic signed [8:0] a, input logic [44:0] b);
    longint p, hi, lo;
    p  = ref_p(a, b);
    hi = (longint'(1) <<< 51) - 1;
    lo = -(longint'(1) <<< 51);
    if (p > hi) return hi;
    if (p < lo) return lo;
    return p;
  endfunction

  function automatic logic ref_ovf(input logic signed [8:0] a, input logic [44:0] b);
    longint p;
    p = ref_p(a, b);
    return (p > (longint'(1) <<< 51) - 1) || (p < -(longint'(1) <<< 51));
  endfunction

  task automatic send_one(input int u, input logic signed [8:0] a, input logic [44:0] b,
                          output logic signed [63:0] d, output logic o, output int lat);
    @(negedge ap_clk);
    iv[u] = 1'b1; d0[u] = a; d1[u] = b; ordy[u] = 1'b1;
    @(negedge ap_clk);
    iv[u] = 1'b0;
    lat   = 1;
    while (!ov[u] && lat < 12) begin
      @(negedge ap_clk);
      lat++;
    end
    d = $signed(dq[u]);
    o = ovfv[u];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [63:0] d;
    logic               o;
    int                 lat;
    logic [44:0]        ones;
    logic signed [8:0]  a_v [10];
    logic [44:0]        b_v [10];
    int                 acc, rx, cnt;
    logic               stalled, drop_seen;
    logic [51:0]        held;

    ones = '1;
    for (int u = 0; u < 3; u++) begin
      iv[u] = 1'b0; ordy[u] = 1'b1; d0[u] = '0; d1[u] = '0;
    end

    // Reset state
    ap_rst_n = 1'b0;
    repeat (3) @(negedge ap_clk);
    chk("rst_out_valid", ov[0], 0);
    chk("rst_dout", $signed(dq[0]), 0);
    chk("rst_ovf", ovfv[0], 0);
    chk("rst_out_valid_s4", ov[1], 0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("rst_in_ready", irdy[0], 1);

    // Basic product and latency
    send_one(0, 9'sd100, 45'd3, d, o, lat);
    chk("basic_dout", d, 300);
    chk("basic_ovf", o, 0);
    chk("basic_latency", lat, 3);

    // Saturation at both bounds
    send_one(0, -9'sd256, ones, d, o, lat);
    chk("sat_min_dout", d, -(64'sd1 <<< 51));
    chk("sat_min_ovf", o, 1);
    send_one(0, 9'sd255, ones, d, o, lat);
    chk("sat_max_dout", d, (64'sd1 <<< 51) - 1);
    chk("sat_max_ovf", o, 1);

    // Unsigned din1 with all-ones pattern
    send_one(0, -9'sd3, ones, d, o, lat);
    chk("unsigned_dout", d, -3 * ((64'sd1 <<< 45) - 1));
    chk("unsigned_ovf", o, 0);

    // SHIFT=4 rounding
    send_one(1, 9'sd5, 45'd3, d, o, lat);
    chk("s4_pos_dout", d, 1);
    chk("s4_pos_ovf", o, 0);
    chk("s4_latency", lat, 3);
    send_one(1, -9'sd5, 45'd3, d, o, lat);
    chk("s4_neg_dout", d, -1);
    chk("s4_neg_ovf", o, 0);
    send_one(1, 9'sd8, 45'd1, d, o, lat);
    chk("s4_tie_dout", d, 1);
    chk("s4_tie_ovf", o, 0);

    // Signed din1
    send_one(2, -9'sd3, ones, d, o, lat);
    chk("signed_dout", d, 3);
    chk("signed_ovf", o, 0);

    // Backpressure stream
    for (int i = 0; i < 10; i++) begin
      a_v[i] = 9'($urandom_range(0, 511));
      b_v[i] = {13'($urandom), 32'($urandom)};
      if (i % 2 == 0) b_v[i] = {29'b0, b_v[i][15:0]};
    end
    acc = 0; rx = 0; stalled = 1'b0; drop_seen = 1'b0; held = '0;
    for (int c = 0; c < 60 && rx < 10; c++) begin
      @(negedge ap_clk);
      ordy[0] = !(c >= 2 && c <= 8);
      iv[0]   = (acc < 10);
      if (acc < 10) begin
        d0[0] = a_v[acc];
        d1[0] = b_v[acc];
      end
      #1;
      if (iv[0] && !irdy[0] && !drop_seen) begin
        drop_seen = 1'b1;
        chk("bp_accepts_before_drop", acc, 3);
      end
      if (c == 9) chk("bp_full_passthru_ready", irdy[0], 1);
      if (ov[0]) begin
        if (stalled) chk("bp_stall_stable", $signed(dq[0]), $signed(held));
        if (ordy[0]) begin
          chk("bp_dout", $signed(dq[0]), ref_dout(a_v[rx], b_v[rx]));
          chk("bp_ovf", ovfv[0], ref_ovf(a_v[rx], b_v[rx]));
          rx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = dq[0];
        end
      end
      if (iv[0] && irdy[0]) acc++;
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    chk("bp_result_count", rx, 10);
    chk("bp_drop_seen", drop_seen, 1);

    // Reset with two results in flight
    @(negedge ap_clk);
    ordy[0] = 1'b0; iv[0] = 1'b1; d0[0] = 9'sd3; d1[0] = 45'd4;
    @(negedge ap_clk);
    d0[0] = 9'sd5; d1[0] = 45'd6;
    @(negedge ap_clk);
    iv[0] = 1'b0;
    @(negedge ap_clk);
    chk("mid_pre_valid", ov[0], 1);
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ov[0], 0);
    chk("mid_rst_dout", $signed(dq[0]), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    ordy[0]  = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge ap_clk);
      if (ov[0]) cnt++;
    end
    chk("mid_no_stale", cnt, 0);
    send_one(0, 9'sd7, 45'd11, d, o, lat);
    chk("mid_post_dout", d, 77);
    chk("mid_post_ovf", o, 0);
    chk("mid_post_latency", lat, 3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/norm1_mul_pipe.md
# norm1_mul_pipe

Pipelined, parametrised signed-by-unsigned multiplier with valid/ready flow control, post-multiply rounding shift and output saturation, for the norm1 (LRN) datapath. It replaces the purely combinational norm1 multiplier cells wherever the product feeds a registered consumer that can stall. Operands are accepted one per cycle, carried through NUM_STAGE register stages, and delivered with a per-result overflow flag.

## Interface
- ID, 1: instance tag, no functional effect
- NUM_STAGE, 3: pipeline depth in cycles, legal range 1..8
- din0_WIDTH, 9: width of signed operand din0
- din1_WIDTH, 45: width of operand din1
- DIN1_SIGNED, 0: 0 = din1 unsigned (zero-extended), 1 = din1 signed
- dout_WIDTH, 52: signed result width
- SHIFT, 0: right shift applied to the product with round-half-up, range 0..(din0_WIDTH+din1_WIDTH)
- ap_clk  in  1  sole clock, rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  din0/din1 valid
- in_ready  out  1  block can accept this cycle
- din0  in  din0_WIDTH  signed operand
- din1  in  din1_WIDTH  operand, signedness per DIN1_SIGNED
- out_valid  out  1  dout/ovf valid
- out_ready  in  1  consumer accepts this cycle
- dout  out  dout_WIDTH  rounded, saturated signed result
- ovf  out  1  result was saturated

## Operation
- Transfer on each side occurs when valid & ready are both high on a rising edge.
- Full product P = signed(din0) * ext(din1), where ext is zero- or sign-extension to din1_WIDTH+1 bits. P is PW = din0_WIDTH+din1_WIDTH+1 bits, exact, with no truncation.
- Rounding: if SHIFT>0, R = (P + 2^(SHIFT-1)) >>> SHIFT, computed at PW+1 bits (arithmetic shift, so ties go toward +inf). If SHIFT=0, R = P.
- Saturation: if R > 2^(dout_WIDTH-1)-1, dout = max and ovf=1. If R < -2^(dout_WIDTH-1), dout = min and ovf=1. Otherwise dout = R and ovf=0.
- Pipeline: stage 1 registers operands. The multiply, round and saturate logic is distributed over the stages, and the final stage registers dout/ovf. With NUM_STAGE=1, all logic sits between the input and the single register.
- Each stage holds a valid bit. A stage advances when it is empty or the stage after it advances. The last stage advances on out_ready.
- in_ready = ~stage1_valid | stage1_advances. in_ready is combinational from out_ready through the valid chain; there is no skid buffer.
- A stalled stage holds data and valid unchanged. Results are never dropped or duplicated, and order is preserved.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the caller): all stage valid bits = 0, so out_valid = 0. dout = 0 and ovf = 0. in_ready = 1 from the first cycle after reset.
- Latency: an accepted input appears at out_valid exactly NUM_STAGE cycles later while out_ready is held high.
- Throughput: 1 result per cycle with out_ready high.
- Capacity: NUM_STAGE results in flight. With out_ready low for NUM_STAGE+ cycles after continuous input, in_ready falls after exactly NUM_STAGE accepts.
- Simultaneous accept and deliver when full: allowed, and the occupancy is unchanged.
- Reset mid-stream: all in-flight results are discarded and nothing is emitted afterward.
- dout/ovf are don't-care when out_valid = 0, but they must stay stable while out_valid=1 & out_ready=0.

## Structure
- Shared package norm1_pkg: function for PW and for the saturation bounds of a given width, plus a rounding-constant helper.
- Sub-module norm1_pipe_stage: one valid/ready register slice of parametrised width, instantiated NUM_STAGE times. Arithmetic sits between slices in the top.

## Test plan
- Defaults, out_ready=1: din0=100, din1=3 → dout=300, ovf=0, out_valid exactly 3 cycles after accept.
- Defaults: din0=-256, din1=2^45-1 → dout=-2^51, ovf=1. Then din0=255, din1=2^45-1 → dout=2^51-1, ovf=1.
- SHIFT=4: inputs (5,3), (-5,3), (8,1) → dout 1, -1, 1, each with ovf=0.
- DIN1_SIGNED=1: din0=-3, din1=all-ones (-1) → dout=3. The same input with DIN1_SIGNED=0 → -3·(2^45-1).
- Backpressure: stream 10 random pairs, hold out_ready=0 for cycles 2..8 → in_ready drops after 3 accepts. All 10 results come out in order, match the reference model, and dout stays stable while stalled.
- Reset asserted mid-stream with 2 results in flight → out_valid=0 immediately, no stale results after release, and the first post-reset input yields the correct result.
